// File: rtl/sk_led_pkg.sv
// sk_led_pkg: FSM state encoding and clock-cycle conversion helpers for sk_led_chain
package sk_led_pkg;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BIT, S_LATCH} state_t;

   function automatic int cyc(input int clk_hz, input int ns);
      return (clk_hz / 1000000) * ns / 1000;
   endfunction

   function automatic int ms_cyc(input int clk_hz, input int ms);
      return (clk_hz / 1000) * ms;
   endfunction

endpackage

// File: rtl/sk_led_bit_timer.sv
// sk_led_bit_timer: times one bit period and shapes the high/low level of the current bit
module sk_led_bit_timer
   import sk_led_pkg::*;
#(
   parameter int T0H  = 15,
   parameter int T1H  = 40,
   parameter int TBIT = 62
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_start,
   input  logic i_run,
   input  logic i_bit,
   output logic o_level,
   output logic o_bit_end
);

   localparam int CW = $clog2(TBIT);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          last;

   // Bit counter: cleared by start, wraps at TBIT-1 so bits of one byte run back to back
   always_comb begin
      last      = cnt_q == CW'(TBIT - 1);
      cnt_d     = (i_start || !i_run || last) ? '0 : cnt_q + 1'b1;
      o_level   = i_run && (cnt_q < (i_bit ? CW'(T1H) : CW'(T0H)));
      o_bit_end = i_run && last;
   end

   // Counter register
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;

endmodule

// File: rtl/sk_led_chain.sv
// sk_led_chain: single-wire RGB/RGBW LED chain driver with a host-writable pixel memory
// Optional SK_LED_AUTO_REFRESH_EN: internal start every REFRESH_MS ms while idle
module sk_led_chain
   import sk_led_pkg::*;
#(
   parameter int LED_COUNT  = 8,
   parameter int CH_PER_LED = 3,
   parameter int ADDR_W     = 6,
   parameter int CLK_HZ     = 50000000,
   parameter int T0H_NS     = 300,
   parameter int T1H_NS     = 800,
   parameter int TBIT_NS    = 1250,
`ifdef SK_LED_AUTO_REFRESH_EN
   parameter int TRST_US    = 80,
   parameter int REFRESH_MS = 20
`else
   parameter int TRST_US    = 80
`endif
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr_n,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [7:0]        i_data,
   output logic [7:0]        o_data,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_sk
);

   localparam int NBYTES = LED_COUNT * CH_PER_LED;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int T0H    = cyc(CLK_HZ, T0H_NS);
   localparam int T1H    = cyc(CLK_HZ, T1H_NS);
   localparam int TBIT   = cyc(CLK_HZ, TBIT_NS);
   localparam int TRST   = cyc(CLK_HZ, TRST_US * 1000);
   localparam int RW     = $clog2(TRST);
   localparam logic [ADDR_W:0]  NB_A     = NBYTES[ADDR_W:0];
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
   localparam logic [RW-1:0]    LAST_RST = RW'(TRST - 1);

   state_t           state_q, state_d;
   logic [7:0]       mem_q [NBYTES];
   logic [7:0]       mem_d [NBYTES];
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
   logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
   logic             busy_q, busy_d, done_q, done_d, pend_q, pend_d, sk_q, sk_d;
   logic             level, bit_end, start, in_range;
   logic [IDX_W-1:0] addr_idx;

   assign in_range = {1'b0, i_addr} < NB_A;
   assign addr_idx = i_addr[IDX_W-1:0];
   assign o_data   = in_range ? mem_q[addr_idx] : 8'h00;
   assign o_busy   = busy_q;
   assign o_done   = done_q;
   assign o_sk     = sk_q;

`ifdef SK_LED_AUTO_REFRESH_EN
   localparam int REF_CYC = ms_cyc(CLK_HZ, REFRESH_MS);
   localparam int FW      = $clog2(REF_CYC);

   logic [FW-1:0] ref_q, ref_d;
   logic          auto_start;

   // Refresh timer: free-runs only while idle and restarts whenever a frame starts
   always_comb begin
      auto_start = (state_q == S_IDLE) && (ref_q == FW'(REF_CYC - 1));
      ref_d      = (state_q != S_IDLE || i_start || auto_start) ? '0 : ref_q + 1'b1;
   end

   // Refresh timer register
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) ref_q <= '0;
      else          ref_q <= ref_d;

   assign start = i_start || auto_start;
`else
   assign start = i_start;
`endif

   sk_led_bit_timer #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT)) u_timer (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_start   (state_q == S_LOAD),
      .i_run     (state_q == S_BIT),
      .i_bit     (shift_q[7]),
      .o_level   (level),
      .o_bit_end (bit_end)
   );

   // Pixel memory write port: in-range host writes land in any state
   always_comb begin
      mem_d = mem_q;
      if (!i_wr_n && in_range) mem_d[addr_idx] = i_data;
   end

   // Frame sequencer: walks bytes and bits, holds the latch gap, honours one queued restart
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      rst_cnt_d  = rst_cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      pend_d     = pend_q || (busy_q && start);
      case (state_q)
         S_IDLE: if (start) begin
            state_d    = S_LOAD;
            busy_d     = 1'b1;
            byte_idx_d = '0;
         end
         S_LOAD: begin
            shift_d   = mem_q[byte_idx_q];
            bit_idx_d = 3'd7;
            state_d   = S_BIT;
         end
         S_BIT: if (bit_end) begin
            if (|bit_idx_q) begin
               shift_d   = shift_q << 1;
               bit_idx_d = bit_idx_q - 1'b1;
            end else if (byte_idx_q != LAST_IDX) begin
               byte_idx_d = byte_idx_q + 1'b1;
               state_d    = S_LOAD;
            end else begin
               rst_cnt_d = '0;
               state_d   = S_LATCH;
            end
         end
         default: begin
            rst_cnt_d = rst_cnt_q + 1'b1;
            if (rst_cnt_q == LAST_RST) begin
               done_d = 1'b1;
               if (pend_q || start) begin
                  pend_d     = 1'b0;
                  byte_idx_d = '0;
                  state_d    = S_LOAD;
               end else begin
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end
      endcase
      sk_d = (state_q == S_BIT) && level;
   end

   // State, datapath and pixel memory registers
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         mem_q      <= '{default: 8'h00};
         shift_q    <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         rst_cnt_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pend_q     <= 1'b0;
         sk_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_q      <= mem_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         rst_cnt_q  <= rst_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pend_q     <= pend_d;
         sk_q       <= sk_d;
      end

endmodule

// File: tb/tb_sk_led_chain.sv
// tb_sk_led_chain: randomized bench decoding the LED line back into bytes and timings
module tb_sk_led_chain;

   localparam int NB   = 6;
   localparam int T0H  = 15;
   localparam int T1H  = 40;
   localparam int TBIT = 62;
   localparam int TRST = 4000;

   logic       clk = 1'b0, rst_n = 1'b0, wr_n = 1'b1, start = 1'b0;
   logic [5:0] addr = '0;
   logic [7:0] wdata = '0, rdata;
   logic       busy, done, sk;

   int checks = 0, errors = 0;
   logic [7:0] mem_m [NB];
   logic [7:0] exp_f [NB];

   int   cyc = 0;
   int   rise_q[$], hi_q[$], done_q[$], bfall_q[$], start_q[$];
   logic sk_p = 1'b0, busy_p = 1'b0;

   sk_led_chain #(.LED_COUNT(2)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_n(wr_n), .i_addr(addr), .i_data(wdata),
      .o_data(rdata), .i_start(start), .o_busy(busy), .o_done(done), .o_sk(sk)
   );

   always #10 clk = ~clk;

   // line monitor: timestamps edges of the serial line and handshake events
   always @(posedge clk) begin
      #1;
      cyc++;
      if (start) start_q.push_back(cyc);
      if (sk && !sk_p) rise_q.push_back(cyc);
      if (!sk && sk_p && rise_q.size() > 0) hi_q.push_back(cyc - rise_q[$]);
      if (done) done_q.push_back(cyc);
      if (busy_p && !busy) bfall_q.push_back(cyc);
      sk_p   = sk;
      busy_p = busy;
   end

   initial begin
      #(20 * 150000);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic write_byte(input int a, input logic [7:0] d);
      @(negedge clk);
      addr = 6'(a); wdata = d; wr_n = 1'b0;
      @(negedge clk);
      wr_n = 1'b1;
      if (a < NB) mem_m[a] = d;
   endtask

   task automatic read_check(input int a, input string tag);
      @(negedge clk);
      addr = 6'(a);
      #1 check($sformatf("%s_rd%0d", tag, a), rdata, (a < NB) ? mem_m[a] : 8'h00);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic clear_q();
      rise_q.delete(); hi_q.delete(); done_q.delete(); bfall_q.delete(); start_q.delete();
   endtask

   task automatic snap();
      for (int i = 0; i < NB; i++) exp_f[i] = mem_m[i];
   endtask

   task automatic rand_fill();
      for (int i = 0; i < NB; i++) write_byte(i, 8'($urandom));
   endtask

   task automatic wait_done(input int n, input string tag);
      int t = 0;
      while (done_q.size() < n && t < 20000) begin @(negedge clk); t++; end
      check({tag, "_done_seen"}, done_q.size() >= n, 1);
   endtask

   task automatic wait_rise(input int n, input string tag);
      int t = 0;
      while (rise_q.size() < n && t < 8000) begin @(negedge clk); t++; end
      check({tag, "_rise_seen"}, rise_q.size() >= n, 1);
   endtask

   // reference decoder: frame f must carry exp_f MSB first with nominal bit/latch timing
   task automatic analyze(input int f, input string tag);
      int b0, j, bad_hi, bad_per;
      logic [7:0] byt;
      logic [2:0] ok;
      b0 = f * NB * 8; bad_hi = 0; bad_per = 0;
      ok = {rise_q.size() >= b0 + NB * 8, hi_q.size() >= b0 + NB * 8, done_q.size() > f};
      check({tag, "_avail"}, ok, 3'b111);
      if (ok == 3'b111) begin
         for (int k = 0; k < NB; k++) begin
            byt = '0;
            for (int i = 0; i < 8; i++) begin
               j   = b0 + 8 * k + i;
               byt = {byt[6:0], hi_q[j] == T1H};
               if (hi_q[j] != T0H && hi_q[j] != T1H) bad_hi++;
               if (j > b0 && rise_q[j] - rise_q[j-1] != ((i == 0) ? TBIT + 1 : TBIT)) bad_per++;
            end
            check($sformatf("%s_byte%0d", tag, k), byt, exp_f[k]);
         end
         check({tag, "_bad_high"}, bad_hi, 0);
         check({tag, "_bad_period"}, bad_per, 0);
         check({tag, "_latch"}, done_q[f] - (rise_q[b0 + NB * 8 - 1] + TBIT) + 1, TRST);
      end
   endtask

   initial begin
      int d, t;
      logic [7:0] n0, n5;
      for (int i = 0; i < NB; i++) mem_m[i] = 8'h00;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_sk", sk, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;
      for (int a = 0; a < 64; a++) read_check(a, "rst");

      // directed frame
      write_byte(0, 8'h80); write_byte(1, 8'h00); write_byte(2, 8'hFF);
      write_byte(3, 8'h01); write_byte(4, 8'h55); write_byte(5, 8'hAA);
      snap(); clear_q(); pulse_start();
      check("t2_busy_rise", busy, 1);
      wait_done(1, "t2");
      repeat (20) @(negedge clk);
      analyze(0, "t2");
      check("t2_nbits", rise_q.size(), NB * 8);
      check("t2_first_rise", (rise_q.size() > 0 && start_q.size() > 0) ? rise_q[0] - start_q[0] : -1, 2);
      check("t2_hi0", (hi_q.size() > 1) ? hi_q[0] : -1, T1H);
      check("t2_hi1", (hi_q.size() > 1) ? hi_q[1] : -1, T0H);
      check("t2_done_pulses", done_q.size(), 1);
      check("t2_busy_fall", (bfall_q.size() > 0 && done_q.size() > 0) ? bfall_q[0] - done_q[0] : -1, 0);
      check("t2_busy_end", busy, 0);

      // out-of-range writes are dropped
      write_byte(6, 8'h5A);
      write_byte(63, 8'hC3);
      read_check(6, "t3");
      read_check(63, "t3");
      read_check(5, "t3");
      read_check(0, "t3");

      // two extra starts during a frame queue exactly one more frame
      rand_fill(); snap(); clear_q(); pulse_start();
      repeat (400) @(negedge clk);
      pulse_start();
      repeat (800) @(negedge clk);
      pulse_start();
      wait_done(2, "t4");
      repeat (100) @(negedge clk);
      check("t4_done_pulses", done_q.size(), 2);
      check("t4_busy_falls", bfall_q.size(), 1);
      check("t4_nbits", rise_q.size(), 2 * NB * 8);
      check("t4_restart", (rise_q.size() > NB * 8) ? rise_q[NB * 8] - done_q[0] : -1, 2);
      analyze(0, "t4a");
      analyze(1, "t4b");

      // coherency: byte 0 already sent, byte 5 not yet loaded
      rand_fill(); snap(); clear_q(); pulse_start();
      wait_rise(12, "t5");
      n0 = mem_m[0] ^ 8'($urandom_range(1, 255));
      n5 = mem_m[5] ^ 8'($urandom_range(1, 255));
      write_byte(0, n0);
      write_byte(5, n5);
      exp_f[5] = n5;
      wait_done(1, "t5a");
      repeat (20) @(negedge clk);
      analyze(0, "t5a");
      snap(); clear_q(); pulse_start();
      wait_done(1, "t5b");
      repeat (20) @(negedge clk);
      analyze(0, "t5b");

      // start on the exact cycle the latch interval ends
      rand_fill(); snap(); clear_q(); pulse_start();
      wait_rise(NB * 8, "t6");
      d = (rise_q.size() > 0) ? rise_q[$] + TBIT + TRST - 1 : 0;
      t = 0;
      while (cyc < d - 1 && t < 8000) begin @(negedge clk); t++; end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(2, "t6");
      repeat (100) @(negedge clk);
      check("t6_first_done", (done_q.size() > 0) ? done_q[0] : -1, d);
      check("t6_done_pulses", done_q.size(), 2);
      check("t6_busy_falls", bfall_q.size(), 1);
      check("t6_restart", (rise_q.size() > NB * 8) ? rise_q[NB * 8] - done_q[0] : -1, 2);
      analyze(0, "t6a");
      analyze(1, "t6b");

      // reset mid-frame
      rand_fill(); clear_q(); pulse_start();
      wait_rise(21, "t7");
      @(negedge clk);
      check("t7_sk_high_before", sk, 1);
      rst_n = 1'b0;
      #1;
      check("t7_sk", sk, 0);
      check("t7_busy", busy, 0);
      check("t7_done", done, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NB; i++) mem_m[i] = 8'h00;
      for (int a = 0; a < NB + 2; a++) read_check(a, "t7");
      repeat (5) @(negedge clk);
      snap(); clear_q(); pulse_start();
      wait_done(1, "t7");
      repeat (20) @(negedge clk);
      analyze(0, "t7");
      check("t7_busy_end", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sk_led_chain.md
Name: sk_led_chain

Overview:
- Parametrised driver for daisy-chained single-wire RGB/RGBW LEDs (SK6805/WS2812 class).
- Holds the frame in an internal byte-addressed pixel memory that a host (SPI-to-GPIO bridge register bus) can write and read.
- On a start strobe, serialises the whole frame MSB-first with programmable T0H/T1H/bit-period timing, then holds the line low for the reset/latch interval.
- Adds what the single-shot driver lacked: arbitrary LED count and channel count, clock-independent timing, a busy/done handshake, queued restart and a guaranteed latch gap.

Parameters:
LED_COUNT, 8, number of LEDs in the chain
CH_PER_LED, 3, bytes per LED (3 = GRB, 4 = GRBW)
ADDR_W, 6, host address width; must satisfy 2^ADDR_W >= LED_COUNT*CH_PER_LED
CLK_HZ, 50000000, i_clk frequency
T0H_NS, 300, high time of a '0' bit
T1H_NS, 800, high time of a '1' bit
TBIT_NS, 1250, total bit period
TRST_US, 80, low time after the last bit (latch)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_wr_n  in  1  active-low write strobe, sampled on the i_clk rising edge
i_addr  in  ADDR_W  byte address into the pixel memory
i_data  in  8  write data
o_data  out  8  read data: memory[i_addr], combinational; 0 for addresses >= NBYTES
i_start  in  1  single-cycle pulse that requests a frame transmit
o_busy  out  1  high from the accepted start until the latch interval ends
o_done  out  1  single-cycle pulse when the latch interval ends
o_sk  out  1  serial LED data line

Behaviour:
- Derived constants, computed with integer math only:
  - NBYTES = LED_COUNT*CH_PER_LED.
  - CYC(ns) = (CLK_HZ/1000000)*ns/1000, truncated.
  - At 50 MHz: T0H = 15, T1H = 40, TBIT = 62, TRST = 4000 cycles.
- Reset (async, i_rst_n low):
  - Pixel memory is cleared to 0.
  - State = IDLE; o_sk = 0, o_busy = 0, o_done = 0; pending flag cleared.
  - Reset mid-frame aborts immediately and drives o_sk low.
- Writes: a byte is written when i_wr_n = 0 and i_addr < NBYTES. Out-of-range writes are ignored. Writes are legal in any state.
- FSM states: IDLE, LOAD, BIT, LATCH.
  - IDLE: o_sk = 0. On i_start go to LOAD and set o_busy on the next edge.
  - LOAD (1 cycle): shift_reg <= memory[byte_idx], bit_idx <= 7, bit_cnt <= 0. Go to BIT.
  - BIT:
    - o_sk = 1 while bit_cnt < (shift_reg[7] ? T1H : T0H), else 0.
    - bit_cnt counts 0..TBIT-1.
    - At TBIT-1, if bit_idx > 0: shift left, decrement bit_idx.
    - Else if byte_idx < NBYTES-1: increment byte_idx and go to LOAD.
    - Else go to LATCH.
    - The LOAD cycle lies outside the bit period; the LOAD bubble is the only inter-byte gap and is allowed (well within tolerance).
  - LATCH:
    - o_sk = 0 for TRST cycles.
    - At the end: pulse o_done.
    - If pending is set: clear it, byte_idx <= 0, go to LOAD, keeping o_busy high.
    - Otherwise go to IDLE and drop o_busy.
- i_start while o_busy = 1 sets pending (no counter). The frame in flight is never truncated.
- i_start in the same cycle as the LATCH→IDLE transition is treated as pending, so the frame restarts.
- Coherency: a byte is sampled at its LOAD.
  - Writes to bytes already sent take effect next frame.
  - Writes to bytes not yet sent go out in this frame.
- o_sk is registered. First rising edge of o_sk occurs 2 cycles after the i_start edge.
- Byte order on the wire is address 0 first; bit order is MSB first. Colour order is host software's responsibility.

Optional Feature:
- Macro: SK_LED_AUTO_REFRESH_EN.
- When defined:
  - Adds parameter REFRESH_MS (default 20).
  - A free-running counter in IDLE issues an internal start every REFRESH_MS ms.
  - The counter restarts on any frame start.
- When undefined: frames are sent only on i_start; no counter logic is generated.

Decomposition:
- Package sk_led_pkg: the FSM state encoding and the CYC() constant function / localparam formulas.
- One sub-module, sk_led_bit_timer: given a bit value and a start strobe, runs bit_cnt and produces the high/low level plus a bit_end pulse. The FSM and pixel memory stay in sk_led_chain.

Test Plan:
- Reset then idle → o_sk = 0, o_busy = 0, every o_data read returns 0x00.
- LED_COUNT = 2, write 0x80,0x00,0xFF,0x01,0x55,0xAA, pulse i_start → 48 bits; first bit high for 40 cycles, second bit high for 15 cycles, each period 62 cycles (+1 LOAD per byte); then o_sk low for 4000 cycles, then o_done pulse and o_busy falls.
- Two i_start pulses during a frame → exactly one additional frame; o_busy stays high continuously across both; two o_done pulses.
- Mid-frame, rewrite byte 0 (already sent) and byte 5 (not yet sent) → byte 5's new value appears on the wire this frame; byte 0's new value appears only in the next frame.
- Write to address NBYTES (6) → ignored; o_data at address 6 reads 0x00; the frame is unchanged.
- Assert i_rst_n low at bit 20 → o_sk goes 0 immediately, o_busy = 0, memory cleared; a subsequent i_start sends all-zero bits.
